lsu_wb: RTL

- Load/store unit that sits directly upstream of the RV32I register file write port (the a3/wd3/we inputs).
- Accepts one memory request from execute, runs a valid/ack transaction on the data-memory bus, and aligns and extends load data.
- Drives the register-file write for loads. Non-pipelined: one request in flight.

---
 rtl/lsu_wb_if.sv | 36 +++
 rtl/lsu_wb.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_wb_if.sv
// Request, data-memory bus and register-file write signals of the lsu_wb load/store unit.
// The master modport is the LSU side; the slave modport is the execute/memory/register-file side.
interface lsu_wb_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_store;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [4:0]  req_rd;
   logic        mem_req;
   logic        mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        rf_we;
   logic [4:0]  rf_a3;
   logic [31:0] rf_wd3;
   logic        done;
   logic        err;
   logic [1:0]  err_cause;

   modport master (
      input  req_valid, req_store, req_funct3, req_addr, req_wdata, req_rd, mem_ack, mem_rdata,
      output req_ready, mem_req, mem_we, mem_be, mem_addr, mem_wdata,
             rf_we, rf_a3, rf_wd3, done, err, err_cause
   );

   modport slave (
      output req_valid, req_store, req_funct3, req_addr, req_wdata, req_rd, mem_ack, mem_rdata,
      input  req_ready, mem_req, mem_we, mem_be, mem_addr, mem_wdata,
             rf_we, rf_a3, rf_wd3, done, err, err_cause
   );
endinterface

// File: rtl/lsu_wb.sv
// Non-pipelined RV32I load/store unit feeding the register-file write port.
// Optional ACCESS timeout is enabled by defining LSU_TIMEOUT_EN.
module lsu_wb #(
   parameter int unsigned TIMEOUT_CYCLES = 32'd255
) (
   input logic       clk,
   input logic       rst_n,
   lsu_wb_if.master  bus
);
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACCESS = 2'd1, S_WB = 2'd2} state_e;

   state_e      state_q, state_d;
   logic        mem_req_q, mem_req_d, mem_we_q, mem_we_d;
   logic [3:0]  mem_be_q, mem_be_d;
   logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
   logic        rf_we_q, rf_we_d;
   logic [4:0]  rf_a3_q, rf_a3_d, rd_q, rd_d;
   logic [31:0] rf_wd3_q, rf_wd3_d;
   logic        done_q, done_d, err_q, err_d, store_q, store_d;
   logic [1:0]  err_cause_q, err_cause_d, off_q, off_d;
   logic [2:0]  funct3_q, funct3_d;
   logic        accept_s, illegal_s, misal_s, timeout_s;

   function automatic logic f3_legal(input logic st, input logic [2:0] f3);
      case (f3)
         3'b000, 3'b001, 3'b010: return 1'b1;
         3'b100, 3'b101:         return ~st;
         default:                return 1'b0;
      endcase
   endfunction

   function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
      case (f3[1:0])
         2'b01:   return off[0];
         2'b10:   return off != 2'b00;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [3:0] store_be(input logic st, input logic [2:0] f3, input logic [1:0] off);
      if (!st) return 4'b1111;
      case (f3[1:0])
         2'b00:   return 4'b0001 << off;
         2'b01:   return off[1] ? 4'b1100 : 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
      case (f3[1:0])
         2'b00:   return {4{wd[7:0]}};
         2'b01:   return {2{wd[15:0]}};
         default: return wd;
      endcase
   endfunction

   function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                                input logic [31:0] rd_word);
      logic [7:0]  b;
      logic [15:0] h;
      b = rd_word[{off, 3'b000} +: 8];
      h = rd_word[{off[1], 4'b0000} +: 16];
      case (f3)
         3'b000:  return {{24{b[7]}}, b};
         3'b001:  return {{16{h[15]}}, h};
         3'b100:  return {24'h00_0000, b};
         3'b101:  return {16'h0000, h};
         default: return rd_word;
      endcase
   endfunction

   assign accept_s  = bus.req_valid & (state_q == S_IDLE);
   assign illegal_s = ~f3_legal(bus.req_store, bus.req_funct3);
   assign misal_s   = misaligned(bus.req_funct3, bus.req_addr[1:0]);

`ifdef LSU_TIMEOUT_EN
   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 32'd1) ? $clog2(TIMEOUT_CYCLES) : 32'd1;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign timeout_s = (state_q == S_ACCESS) & ~bus.mem_ack &
                      (cnt_q == CNT_W'(TIMEOUT_CYCLES - 32'd1));

   // ACCESS wait counter, cleared whenever ACCESS is (re)entered
   always_comb begin
      cnt_d = cnt_q;
      if (accept_s) begin
         cnt_d = '0;
      end else if (state_q == S_ACCESS) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Timeout counter register
   always_ff @(posedge clk) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end
`else
   assign timeout_s = 1'b0;
`endif

   // State and registered output / request-context flops
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_be_q    <= 4'b0000;
         mem_addr_q  <= 32'h0000_0000;
         mem_wdata_q <= 32'h0000_0000;
         rf_we_q     <= 1'b0;
         rf_a3_q     <= 5'd0;
         rf_wd3_q    <= 32'h0000_0000;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         err_cause_q <= 2'b00;
         store_q     <= 1'b0;
         funct3_q    <= 3'b000;
         off_q       <= 2'b00;
         rd_q        <= 5'd0;
      end else begin
         state_q     <= state_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_be_q    <= mem_be_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         rf_we_q     <= rf_we_d;
         rf_a3_q     <= rf_a3_d;
         rf_wd3_q    <= rf_wd3_d;
         done_q      <= done_d;
         err_q       <= err_d;
         err_cause_q <= err_cause_d;
         store_q     <= store_d;
         funct3_q    <= funct3_d;
         off_q       <= off_d;
         rd_q        <= rd_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (accept_s && !illegal_s && !misal_s) state_d = S_ACCESS;
            else                                    state_d = S_IDLE;
         end
         S_ACCESS: begin
            if (bus.mem_ack)    state_d = store_q ? S_IDLE : S_WB;
            else if (timeout_s) state_d = S_IDLE;
            else                state_d = S_ACCESS;
         end
         S_WB:    state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Next values of the registered outputs; pulses default low
   always_comb begin
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_be_d    = mem_be_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      rf_we_d     = 1'b0;
      rf_a3_d     = rf_a3_q;
      rf_wd3_d    = rf_wd3_q;
      done_d      = 1'b0;
      err_d       = 1'b0;
      err_cause_d = 2'b00;
      store_d     = store_q;
      funct3_d    = funct3_q;
      off_d       = off_q;
      rd_d        = rd_q;
      case (state_q)
         S_IDLE: begin
            if (accept_s) begin
               store_d  = bus.req_store;
               funct3_d = bus.req_funct3;
               off_d    = bus.req_addr[1:0];
               rd_d     = bus.req_rd;
               if (illegal_s || misal_s) begin
                  err_d       = 1'b1;
                  done_d      = 1'b1;
                  err_cause_d = illegal_s ? 2'b10 : 2'b01;
               end else begin
                  mem_req_d   = 1'b1;
                  mem_we_d    = bus.req_store;
                  mem_be_d    = store_be(bus.req_store, bus.req_funct3, bus.req_addr[1:0]);
                  mem_addr_d  = {bus.req_addr[31:2], 2'b00};
                  mem_wdata_d = store_data(bus.req_funct3, bus.req_wdata);
               end
            end else begin
               mem_req_d = 1'b0;
            end
         end
         S_ACCESS: begin
            if (bus.mem_ack) begin
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
               done_d    = 1'b1;
               if (!store_q) begin
                  rf_we_d  = (rd_q != 5'd0);
                  rf_a3_d  = rd_q;
                  rf_wd3_d = load_extract(funct3_q, off_q, bus.mem_rdata);
               end else begin
                  rf_we_d  = 1'b0;
               end
            end else if (timeout_s) begin
               mem_req_d   = 1'b0;
               mem_we_d    = 1'b0;
               done_d      = 1'b1;
               err_d       = 1'b1;
               err_cause_d = 2'b11;
            end else begin
               mem_req_d = 1'b1;
            end
         end
         S_WB:    mem_req_d = 1'b0;
         default: mem_req_d = 1'b0;
      endcase
   end

   assign bus.req_ready = (state_q == S_IDLE);
   assign bus.mem_req   = mem_req_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_be    = mem_be_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.rf_we     = rf_we_q;
   assign bus.rf_a3     = rf_a3_q;
   assign bus.rf_wd3    = rf_wd3_q;
   assign bus.done      = done_q;
   assign bus.err       = err_q;
   assign bus.err_cause = err_cause_q;
endmodule
